// File: rtl/pool_result_streamer.sv
// -----------------------------------------------------------------------------
// pool_result_streamer
//
// Reads pooled results back out of split_ram and streams them one RAM_WIDTH
// word at a time over a valid/ready interface. Each split_ram address holds
// one line of NUM_RAMS words with bank 0 in the LSBs. Words are emitted bank 0
// first, line by line, until NUM_WORDS words have been sent. Banks of the
// final line past the last valid word are never emitted.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   start      begin a stream (only honoured in IDLE)
//   data_rd    split_ram read data, valid the cycle after addr_rd is sampled
//   addr_rd    split_ram read address (registered)
//   out_data   streamed word
//   out_valid  out_data valid
//   out_ready  consumer accepts the word when out_valid && out_ready
//   out_last   marks the final (NUM_WORDS-th) word
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module pool_result_streamer #(
  parameter int NUM_RAMS  = 7,
  parameter int RAM_DEPTH = 256,
  parameter int RAM_WIDTH = 16,
  parameter int NUM_WORDS = 180
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [RAM_WIDTH*NUM_RAMS-1:0] data_rd,
  output logic [$clog2(RAM_DEPTH)-1:0]  addr_rd,
  output logic [RAM_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int ADDR_W   = $clog2(RAM_DEPTH);
  localparam int IDX_W    = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
  localparam int LINES    = (NUM_WORDS + NUM_RAMS - 1) / NUM_RAMS;
  localparam int LAST_CNT = NUM_WORDS - (LINES - 1) * NUM_RAMS;

  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LAST_CNT - 1);
  localparam logic [IDX_W-1:0]  LINE_END  = IDX_W'(NUM_RAMS - 1);
  // The final line may hold only one word, in which case the first word
  // loaded for that line is already the last one.
  localparam bit FIRST_IS_LAST = (LAST_CNT == 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    STREAM,
    DONE
  } state_t;

  state_t                          state_reg;
  logic [ADDR_W-1:0]               addr_rd_reg;
  logic [ADDR_W-1:0]               line_reg;
  logic [IDX_W-1:0]                word_idx_reg;
  logic [RAM_WIDTH*NUM_RAMS-1:0]   line_buf_reg;
  logic [RAM_WIDTH-1:0]            out_data_reg;
  logic                            out_valid_reg;
  logic                            out_last_reg;
  logic                            busy_reg;
  logic                            done_reg;

  // Captured line viewed as an array of words so the next word can be
  // selected by index.
  logic [RAM_WIDTH-1:0] buf_words [NUM_RAMS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RAMS; gi++) begin : g_words
      assign buf_words[gi] = line_buf_reg[gi*RAM_WIDTH +: RAM_WIDTH];
    end
  endgenerate

  logic [IDX_W-1:0] word_idx_next;
  logic             last_next;

  assign word_idx_next = word_idx_reg + 1'b1;
  assign last_next     = (line_reg == LAST_LINE) && (word_idx_next == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_rd_reg   <= '0;
      line_reg      <= '0;
      word_idx_reg  <= '0;
      line_buf_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          addr_rd_reg <= '0;
          line_reg    <= '0;
          if (start) begin
            busy_reg  <= 1'b1;
            state_reg <= ADDR;
          end
        end

        // split_ram samples addr_rd at the end of this cycle.
        ADDR: begin
          state_reg <= LOAD;
        end

        // data_rd is valid now; the first word goes straight to the output
        // register since line_buf is only written at this same edge.
        LOAD: begin
          line_buf_reg  <= data_rd;
          word_idx_reg  <= '0;
          out_data_reg  <= data_rd[RAM_WIDTH-1:0];
          out_last_reg  <= (line_reg == LAST_LINE) && FIRST_IS_LAST;
          out_valid_reg <= 1'b1;
          state_reg     <= STREAM;
        end

        // out_valid is always high here, so out_ready alone is the handshake.
        // Without it every output and counter simply holds.
        STREAM: begin
          if (out_ready) begin
            if (out_last_reg) begin
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              done_reg      <= 1'b1;
              state_reg     <= DONE;
            end else if (word_idx_reg == LINE_END) begin
              line_reg      <= line_reg + 1'b1;
              addr_rd_reg   <= addr_rd_reg + 1'b1;
              out_valid_reg <= 1'b0;
              state_reg     <= ADDR;
            end else begin
              word_idx_reg <= word_idx_next;
              out_data_reg <= buf_words[word_idx_next];
              out_last_reg <= last_next;
            end
          end
        end

        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign addr_rd   = addr_rd_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_pool_result_streamer.sv
`timescale 1ns/1ps
module tb_pool_result_streamer;

  localparam int NR = 7;
  localparam int W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  logic ready;
  int   sel;

  int n_cmp = 0;
  int n_bad = 0;

  // Three instances: default (180 words), 14 words (full final line), 1 word.
  logic            start_a, start_b, start_c;
  logic [NR*W-1:0] rd_a, rd_b, rd_c;
  logic [7:0]      addr_a, addr_b, addr_c;
  logic [W-1:0]    data_a, data_b, data_c;
  logic            valid_a, valid_b, valid_c;
  logic            last_a, last_b, last_c;
  logic            busy_a, busy_b, busy_c;
  logic            done_a, done_b, done_c;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  pool_result_streamer u_a (
    .clk(clk), .rst(rst), .start(start_a), .data_rd(rd_a), .addr_rd(addr_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready), .out_last(last_a),
    .busy(busy_a), .done(done_a)
  );

  pool_result_streamer #(.NUM_WORDS(14)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .data_rd(rd_b), .addr_rd(addr_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready), .out_last(last_b),
    .busy(busy_b), .done(done_b)
  );

  pool_result_streamer #(.NUM_WORDS(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .data_rd(rd_c), .addr_rd(addr_c),
    .out_data(data_c), .out_valid(valid_c), .out_ready(ready), .out_last(last_c),
    .busy(busy_c), .done(done_c)
  );

  // split_ram model: line k, bank b holds k*16+b; one cycle read latency.
  function automatic logic [NR*W-1:0] line_word(input logic [7:0] a);
    logic [NR*W-1:0] v;
    v = '0;
    for (int b = 0; b < NR; b++) v[b*W +: W] = W'(int'(a) * 16 + b);
    return v;
  endfunction

  always @(posedge clk) begin
    rd_a <= line_word(addr_a);
    rd_b <= line_word(addr_b);
    rd_c <= line_word(addr_c);
  end

  // Observation mux onto the instance under test.
  logic [7:0]   mon_addr;
  logic [W-1:0] mon_data;
  logic         mon_valid, mon_last, mon_busy, mon_done;

  always_comb begin
    mon_addr = addr_a; mon_data = data_a; mon_valid = valid_a;
    mon_last = last_a; mon_busy = busy_a; mon_done  = done_a;
    case (sel)
      1: begin
        mon_addr = addr_b; mon_data = data_b; mon_valid = valid_b;
        mon_last = last_b; mon_busy = busy_b; mon_done  = done_b;
      end
      2: begin
        mon_addr = addr_c; mon_data = data_c; mon_valid = valid_c;
        mon_last = last_c; mon_busy = busy_c; mon_done  = done_c;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one stream on the selected instance, scoreboarding every word.
  task automatic run_stream(input int n_words, input bit bp, input bit poke_start,
                            input int abort_at);
    int k, cyc, first_valid, max_addr, n_lines, exp_word;
    bit finished, aborted, held;
    logic [W-1:0] held_data;
    n_lines = (n_words + NR - 1) / NR;
    k = 0; cyc = 0; first_valid = -1; max_addr = 0;
    finished = 0; aborted = 0; held = 0; held_data = '0;

    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (int'(mon_addr) > max_addr) max_addr = int'(mon_addr);
      if (mon_valid && first_valid < 0) first_valid = cyc;
      if (mon_done) begin
        chk("done_word_count", k, n_words);
        chk("done_valid", mon_valid, 0);
        chk("done_busy", mon_busy, 1);
        if (poke_start) start = 1'b1;
        finished = 1;
      end else if (mon_valid) begin
        if (held) chk("hold_data", mon_data, held_data);
        chk("last_flag", mon_last, (k == n_words - 1) ? 1 : 0);
        if (ready) begin
          exp_word = (k / NR) * 16 + (k % NR);
          chk("word_data", mon_data, exp_word);
          chk("word_addr", mon_addr, k / NR);
          k++;
          held = 0;
          if (abort_at > 0 && k == abort_at) begin
            aborted = 1;
            finished = 1;
          end
        end else begin
          held = 1;
          held_data = mon_data;
        end
        if (poke_start && k == 60) start = 1'b1;
      end
    end

    if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d words expected %0d", k, n_words);
      start = 1'b0;
      return;
    end

    chk("first_valid_latency", first_valid, 3);

    if (aborted) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", mon_valid, 0);
      chk("abort_busy", mon_busy, 0);
      chk("abort_addr", mon_addr, 0);
      chk("abort_done", mon_done, 0);
      repeat (4) begin
        @(negedge clk);
        chk("abort_no_done", mon_done, 0);
        chk("abort_idle", mon_busy, 0);
      end
      return;
    end

    chk("max_addr", max_addr, n_lines - 1);
    @(negedge clk);
    start = 1'b0;
    chk("post_done_pulse", mon_done, 0);
    chk("post_busy", mon_busy, 0);
    chk("post_valid", mon_valid, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stay_idle", mon_busy, 0);
    end
  endtask

  typedef struct {
    logic         start;
    logic         ready;
    logic         valid;
    logic [W-1:0] data;
    logic         last;
    logic         busy;
    logic         done;
    logic [7:0]   addr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // NUM_WORDS=1 trace: inputs applied for an edge, outputs expected after it.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0}; // -> ADDR
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0}; // -> LOAD
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0, 8'd0}; // -> STREAM
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0, 8'd0}; // held
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 8'd0}; // accept -> DONE
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0}; // start in DONE ignored
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0}; // still IDLE

    rst = 1'b1; start = 1'b0; ready = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_valid", mon_valid, 0);
      chk("reset_busy", mon_busy, 0);
      chk("reset_done", mon_done, 0);
      chk("reset_addr", mon_addr, 0);
      chk("reset_data", mon_data, 0);
      chk("reset_last", mon_last, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Single-word stream, cycle by cycle.
    sel = 2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = vecs[i].start;
      ready = vecs[i].ready;
      @(posedge clk);
      #1;
      chk("vec_valid", mon_valid, vecs[i].valid);
      if (vecs[i].valid) chk("vec_data", mon_data, vecs[i].data);
      chk("vec_last", mon_last, vecs[i].last);
      chk("vec_busy", mon_busy, vecs[i].busy);
      chk("vec_done", mon_done, vecs[i].done);
      chk("vec_addr", mon_addr, vecs[i].addr);
      $display("vec %0d: valid=%0d data=%0d last=%0d busy=%0d done=%0d addr=%0d",
               i, mon_valid, mon_data, mon_last, mon_busy, mon_done, mon_addr);
    end
    @(negedge clk);
    start = 1'b0;
    run_stream(1, 1'b0, 1'b0, 0);
    $display("stream NUM_WORDS=1 complete");

    sel = 0;
    run_stream(180, 1'b0, 1'b0, 0);
    $display("stream 180 words, ready=1 complete");
    run_stream(180, 1'b1, 1'b0, 0);
    $display("stream 180 words, random backpressure complete");

    sel = 1;
    run_stream(14, 1'b0, 1'b0, 0);
    $display("stream NUM_WORDS=14 complete");
    run_stream(14, 1'b1, 1'b0, 0);
    $display("stream NUM_WORDS=14 with backpressure complete");

    sel = 0;
    run_stream(180, 1'b0, 1'b1, 0);
    $display("stream 180 words with stray start pulses complete");
    run_stream(180, 1'b1, 1'b0, 50);
    $display("stream aborted by reset after word 50");
    run_stream(180, 1'b0, 1'b0, 0);
    $display("stream 180 words after reset complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
